reg_status_ctrl: RTL and testbench
==================================

# reg_status_ctrl

Register-status controller for the out-of-order core: owns the 32 x 32-bit architectural register storage together with a per-register busy bit and ROB tag, and sequences every access to it. Issue reads two source operands (value or pending ROB tag) and renames a destination; ROB commit writes back values and retires renames; a flush clears all pending renames. After reset, a built-in sequencer zeroes the storage one entry per cycle before accepting traffic.

## Interface
Parameters:
- REG_NUM, 32, number of architectural registers (index width 5)
- ROB_TAG_W, 4, width of ROB tag

Ports:
- clk_in  input  1  clock; all state updates on rising edge
- rst_n_in  input  1  synchronous, active-low reset
- rdy_in  input  1  global enable; low = hold all state
- ready_out  output  1  high once init done; issue/commit/flush ignored while low
- issue_valid_in  input  1  issue request this cycle (rename rd)
- rs1_in, rs2_in  input  5  source register indices
- rd_in  input  5  destination register to rename
- rd_tag_in  input  ROB_TAG_W  ROB tag assigned to rd
- rs1_busy_out, rs2_busy_out  output  1  operand pending (combinational)
- rs1_value_out, rs2_value_out  output  32  operand value, valid when busy low
- rs1_tag_out, rs2_tag_out  output  ROB_TAG_W  pending ROB tag, valid when busy high
- commit_valid_in  input  1  ROB commit this cycle
- commit_rd_in  input  5  committed destination
- commit_tag_in  input  ROB_TAG_W  tag of committing entry
- commit_value_in  input  32  committed result
- flush_in  input  1  mispredict flush: discard all renames

## Operation
- State machine: INIT -> RUN. Reset forces INIT, init counter 0, all busy bits 0, ready_out 0.
- INIT: each enabled edge writes 0 to reg[counter], counter+1; after entry REG_NUM-1 is written, move to RUN, ready_out 1. Counter width 5, no wrap beyond 31.
- RUN, reads (combinational from current state): busy_out = busy[rs] & ~bypass; value_out = bypass ? commit_value_in : reg[rs]; tag_out = tag[rs]. Bypass = commit_valid_in & commit_rd_in==rs & busy[rs] & tag[rs]==commit_tag_in & rs!=0.
- Index 0: value_out always 0, busy_out always 0; never written, never renamed.
- Commit (rd!=0): reg[rd] <= commit_value_in unconditionally; busy[rd] cleared only if tag[rd]==commit_tag_in.
- Issue (issue_valid_in, rd!=0): busy[rd] <= 1, tag[rd] <= rd_tag_in. Source reads in the same cycle see pre-rename state (add x1,x1,x2 reads old x1).
- Issue and commit to same rd in same cycle: value written, busy stays 1, tag = new rd_tag_in.
- flush_in: all busy bits cleared; overrides same-cycle issue rename; same-cycle commit value write still performed.
- rdy_in low: no state change of any kind (INIT counter frozen); outputs still reflect current state.
- During INIT: read outputs are don't-care; issue/commit/flush inputs ignored.

## Timing
- Reads: zero latency (combinational), including commit bypass.
- Writes, renames, busy clears, flush: visible on outputs the cycle after the edge.
- Init: exactly REG_NUM enabled edges after reset release; ready_out high on the output after the 32nd.
- Reset mid-operation (any state): returns to INIT, all busy cleared, storage re-zeroed over 32 cycles.
- Reset values: ready_out 0, all busy 0, busy_out outputs 0.

## Test plan
- Reset, rdy_in 1: ready_out 0 for 32 cycles, 1 after; all reads return value 0, busy 0; toggle rdy_in low 5 cycles mid-init -> ready_out delayed exactly 5 cycles.
- Issue rd=5 tag=3; next cycle rs1=5 -> busy 1, tag 3; commit rd=5 tag=3 value 0xDEADBEEF same cycle as read -> busy 0, value 0xDEADBEEF (bypass); next cycle busy 0 from storage.
- Rename x7 tag 2 then tag 9; commit x7 tag 2 value 0x11 -> busy stays 1, tag 9, reg holds 0x11; commit tag 9 value 0x22 -> busy 0, value 0x22.
- Same cycle: issue rd=4 tag 6 and commit rd=4 (matching old tag 1) -> next cycle busy 1, tag 6; rs1=4 with rd=4 issue reads old state.
- Rename x1,x2,x3; flush with simultaneous issue rd=8 and commit x2 value 0x55 -> all busy 0, x8 not busy, x2 reads 0x55.
- Issue rd=0 and commit rd=0 value 0xFFFF -> rs1=0 reads value 0, busy 0; rst_n_in low 1 cycle in RUN -> ready_out 0, all registers read 0 after re-init.

Source files
------------

// File: rtl/reg_status_ctrl_if.sv
// Bus bundle between the issue/commit side of the core and reg_status_ctrl.
// Carries the operand-read, rename, commit and flush signals plus a debug view of the FSM.
interface reg_status_ctrl_if #(
  parameter int ROB_TAG_W = 4
);
  // Handshake: there is no per-transaction ready. issue_valid_in, commit_valid_in and
  // flush_in are single-cycle strobes, taken on any rising edge where rdy_in is high and
  // ready_out is already high. While ready_out is low they are ignored, not queued.
  logic                 rdy_in;
  logic                 ready_out;
  logic                 issue_valid_in;
  logic [4:0]           rs1_in;
  logic [4:0]           rs2_in;
  logic [4:0]           rd_in;
  logic [ROB_TAG_W-1:0] rd_tag_in;
  logic                 rs1_busy_out;
  logic                 rs2_busy_out;
  logic [31:0]          rs1_value_out;
  logic [31:0]          rs2_value_out;
  logic [ROB_TAG_W-1:0] rs1_tag_out;
  logic [ROB_TAG_W-1:0] rs2_tag_out;
  logic                 commit_valid_in;
  logic [4:0]           commit_rd_in;
  logic [ROB_TAG_W-1:0] commit_tag_in;
  logic [31:0]          commit_value_in;
  logic                 flush_in;
  logic                 dbg_state;

  modport slave (
    input  rdy_in, issue_valid_in, rs1_in, rs2_in, rd_in, rd_tag_in,
    input  commit_valid_in, commit_rd_in, commit_tag_in, commit_value_in, flush_in,
    output ready_out, rs1_busy_out, rs2_busy_out, rs1_value_out, rs2_value_out,
    output rs1_tag_out, rs2_tag_out, dbg_state
  );

  modport master (
    output rdy_in, issue_valid_in, rs1_in, rs2_in, rd_in, rd_tag_in,
    output commit_valid_in, commit_rd_in, commit_tag_in, commit_value_in, flush_in,
    input  ready_out, rs1_busy_out, rs2_busy_out, rs1_value_out, rs2_value_out,
    input  rs1_tag_out, rs2_tag_out, dbg_state
  );
endinterface

// File: rtl/reg_status_ctrl.sv
// Architectural register file with per-register busy bit and ROB tag for rename tracking.
// Zeroes storage one entry per enabled cycle after reset, then serves reads/renames/commits.
module reg_status_ctrl #(
  parameter int REG_NUM   = 32,
  parameter int ROB_TAG_W = 4
) (
  input logic             clk_in,
  input logic             rst_n_in,
  reg_status_ctrl_if.slave bus
);
  localparam int IDX_W = 5;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REG_NUM - 1);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               state;
  logic                 ready_q;
  logic [IDX_W-1:0]     init_cnt;
  logic [31:0]          regs [REG_NUM];
  logic [REG_NUM-1:0]   busy;
  logic [ROB_TAG_W-1:0] tags [REG_NUM];

  logic byp1;
  logic byp2;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state    <= INIT;
      init_cnt <= '0;
      busy     <= '0;
      ready_q  <= 1'b0;
    end else if (bus.rdy_in) begin
      unique case (state)
        INIT: begin
          regs[init_cnt] <= '0;
          if (init_cnt == LAST_IDX) begin
            state   <= RUN;
            ready_q <= 1'b1;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        RUN: begin
          // The value lands even on a stale tag; only the busy clear is tag-qualified.
          if (bus.commit_valid_in && (bus.commit_rd_in != '0)) begin
            regs[bus.commit_rd_in] <= bus.commit_value_in;
            if (tags[bus.commit_rd_in] == bus.commit_tag_in) begin
              busy[bus.commit_rd_in] <= 1'b0;
            end
          end
          // Later assignments win: a rename beats a same-cycle clear, a flush beats both.
          if (bus.issue_valid_in && (bus.rd_in != '0)) begin
            busy[bus.rd_in] <= 1'b1;
            tags[bus.rd_in] <= bus.rd_tag_in;
          end
          if (bus.flush_in) begin
            busy <= '0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  // Forward a result committing this cycle to a source still waiting on that exact tag.
  assign byp1 = bus.commit_valid_in && (bus.commit_rd_in == bus.rs1_in) &&
                busy[bus.rs1_in] && (tags[bus.rs1_in] == bus.commit_tag_in) &&
                (bus.rs1_in != '0);
  assign byp2 = bus.commit_valid_in && (bus.commit_rd_in == bus.rs2_in) &&
                busy[bus.rs2_in] && (tags[bus.rs2_in] == bus.commit_tag_in) &&
                (bus.rs2_in != '0);

  assign bus.rs1_busy_out  = (bus.rs1_in != '0) && busy[bus.rs1_in] && !byp1;
  assign bus.rs2_busy_out  = (bus.rs2_in != '0) && busy[bus.rs2_in] && !byp2;
  assign bus.rs1_value_out = (bus.rs1_in == '0) ? 32'd0 :
                             (byp1 ? bus.commit_value_in : regs[bus.rs1_in]);
  assign bus.rs2_value_out = (bus.rs2_in == '0) ? 32'd0 :
                             (byp2 ? bus.commit_value_in : regs[bus.rs2_in]);
  assign bus.rs1_tag_out   = tags[bus.rs1_in];
  assign bus.rs2_tag_out   = tags[bus.rs2_in];

  assign bus.ready_out = ready_q;
  assign bus.dbg_state = state;
endmodule

// File: tb/tb_reg_status_ctrl.sv
// Directed bench for reg_status_ctrl: init timing, operand reads, rename/commit/flush
// sequences from a vector table, and re-initialisation after a mid-run reset.
module tb_reg_status_ctrl;
  localparam int TW = 4;

  logic clk_in;
  logic rst_n_in;
  int   n_cmp;
  int   n_fail;

  reg_status_ctrl_if #(.ROB_TAG_W(TW)) bus ();

  reg_status_ctrl #(.REG_NUM(32), .ROB_TAG_W(TW)) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .bus      (bus)
  );

  // ---------------- clock ----------------
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic          iv;
    logic [4:0]    rd;
    logic [TW-1:0] rtag;
    logic          cv;
    logic [4:0]    crd;
    logic [TW-1:0] ctag;
    logic [31:0]   cval;
    logic          fl;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic          eb1;
    logic [31:0]   ev1;
    logic [TW-1:0] et1;
    logic          eb2;
    logic [31:0]   ev2;
    logic [TW-1:0] et2;
  } vec_t;

  vec_t vecs [23];

  function automatic vec_t mk(
    input logic iv, input logic [4:0] rd, input logic [TW-1:0] rtag,
    input logic cv, input logic [4:0] crd, input logic [TW-1:0] ctag,
    input logic [31:0] cval, input logic fl,
    input logic [4:0] rs1, input logic [4:0] rs2,
    input logic eb1, input logic [31:0] ev1, input logic [TW-1:0] et1,
    input logic eb2, input logic [31:0] ev2, input logic [TW-1:0] et2);
    vec_t v;
    v.iv = iv;   v.rd = rd;   v.rtag = rtag;
    v.cv = cv;   v.crd = crd; v.ctag = ctag; v.cval = cval; v.fl = fl;
    v.rs1 = rs1; v.rs2 = rs2;
    v.eb1 = eb1; v.ev1 = ev1; v.et1 = et1;
    v.eb2 = eb2; v.ev2 = ev2; v.et2 = et2;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    bus.issue_valid_in  = 1'b0;
    bus.rd_in           = '0;
    bus.rd_tag_in       = '0;
    bus.commit_valid_in = 1'b0;
    bus.commit_rd_in    = '0;
    bus.commit_tag_in   = '0;
    bus.commit_value_in = '0;
    bus.flush_in        = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_operand(input string tag, input logic [4:0] rs, input logic eb,
                               input logic [31:0] ev, input logic [TW-1:0] et,
                               input logic b, input logic [31:0] v, input logic [TW-1:0] t);
    check($sformatf("%s_x%0d_busy", tag, rs), 32'(b), 32'(eb));
    if (eb) check($sformatf("%s_x%0d_tag", tag, rs), 32'(t), 32'(et));
    else    check($sformatf("%s_x%0d_value", tag, rs), v, ev);
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 16; k++) begin
      bus.rs1_in = 5'(2 * k);
      bus.rs2_in = 5'(2 * k + 1);
      #1;
      check_operand(tag, bus.rs1_in, 1'b0, 32'd0, '0, bus.rs1_busy_out, bus.rs1_value_out, bus.rs1_tag_out);
      check_operand(tag, bus.rs2_in, 1'b0, 32'd0, '0, bus.rs2_busy_out, bus.rs2_value_out, bus.rs2_tag_out);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    n_cmp  = 0;
    n_fail = 0;

    //                iv rd rtag cv crd ctag cval          fl rs1 rs2  eb1 ev1           et1 eb2 ev2           et2
    vecs[0]  = mk(1, 5, 3, 0, 0, 0, 32'h0,        0, 5, 0,  0, 32'h0,        0, 0, 32'h0,        0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        0, 5, 6,  1, 32'h0,        3, 0, 32'h0,        0);
    vecs[2]  = mk(0, 0, 0, 1, 5, 3, 32'hDEADBEEF, 0, 5, 5,  0, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        0, 5, 0,  0, 32'hDEADBEEF, 0, 0, 32'h0,        0);
    vecs[4]  = mk(1, 7, 2, 0, 0, 0, 32'h0,        0, 7, 5,  0, 32'h0,        0, 0, 32'hDEADBEEF, 0);
    vecs[5]  = mk(1, 7, 9, 0, 0, 0, 32'h0,        0, 7, 7,  1, 32'h0,        2, 1, 32'h0,        2);
    vecs[6]  = mk(0, 0, 0, 1, 7, 2, 32'h11,       0, 7, 0,  1, 32'h0,        9, 0, 32'h0,        0);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        0, 7, 7,  1, 32'h0,        9, 1, 32'h0,        9);
    vecs[8]  = mk(0, 0, 0, 1, 7, 9, 32'h22,       0, 7, 0,  0, 32'h22,       0, 0, 32'h0,        0);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        0, 7, 5,  0, 32'h22,       0, 0, 32'hDEADBEEF, 0);
    vecs[10] = mk(1, 4, 1, 0, 0, 0, 32'h0,        0, 4, 0,  0, 32'h0,        0, 0, 32'h0,        0);
    vecs[11] = mk(1, 4, 6, 1, 4, 1, 32'h44,       0, 4, 4,  0, 32'h44,       0, 0, 32'h44,       0);
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 32'h0,        0, 4, 0,  1, 32'h0,        6, 0, 32'h0,        0);
    vecs[13] = mk(0, 0, 0, 1, 4, 6, 32'h66,       0, 4, 7,  0, 32'h66,       0, 0, 32'h22,       0);
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 32'h0,        0, 4, 0,  0, 32'h66,       0, 0, 32'h0,        0);
    vecs[15] = mk(1, 1, 1, 0, 0, 0, 32'h0,        0, 1, 2,  0, 32'h0,        0, 0, 32'h0,        0);
    vecs[16] = mk(1, 2, 2, 0, 0, 0, 32'h0,        0, 1, 2,  1, 32'h0,        1, 0, 32'h0,        0);
    vecs[17] = mk(1, 3, 3, 0, 0, 0, 32'h0,        0, 2, 3,  1, 32'h0,        2, 0, 32'h0,        0);
    vecs[18] = mk(1, 8, 5, 1, 2, 7, 32'h55,       1, 3, 2,  1, 32'h0,        3, 1, 32'h0,        2);
    vecs[19] = mk(0, 0, 0, 0, 0, 0, 32'h0,        0, 1, 2,  0, 32'h0,        0, 0, 32'h55,       0);
    vecs[20] = mk(0, 0, 0, 0, 0, 0, 32'h0,        0, 3, 8,  0, 32'h0,        0, 0, 32'h0,        0);
    vecs[21] = mk(1, 0, 4, 1, 0, 0, 32'hFFFF,     0, 0, 0,  0, 32'h0,        0, 0, 32'h0,        0);
    vecs[22] = mk(0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0,  0, 32'h0,        0, 0, 32'h0,        0);

    // ---------------- reset ----------------
    idle_inputs();
    bus.rdy_in = 1'b1;
    bus.rs1_in = 5'd3;
    bus.rs2_in = 5'd9;
    rst_n_in   = 1'b0;
    step();
    step();
    check("reset_ready", 32'(bus.ready_out), 32'd0);
    check("reset_rs1_busy", 32'(bus.rs1_busy_out), 32'd0);
    check("reset_rs2_busy", 32'(bus.rs2_busy_out), 32'd0);
    rst_n_in = 1'b1;

    // Init with a 5-cycle stall: 10 + 21 enabled edges keep ready low, the 32nd raises it.
    for (int k = 0; k < 10; k++) step();
    check("init_ready_after10", 32'(bus.ready_out), 32'd0);
    bus.rdy_in = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check("init_ready_stalled", 32'(bus.ready_out), 32'd0);
    bus.rdy_in = 1'b1;
    for (int k = 0; k < 21; k++) step();
    check("init_ready_after31", 32'(bus.ready_out), 32'd0);
    step();
    check("init_ready_after32", 32'(bus.ready_out), 32'd1);
    check_all_zero("post_init");

    // ---------------- vector table ----------------
    for (int i = 0; i < 23; i++) begin
      bus.issue_valid_in  = vecs[i].iv;
      bus.rd_in           = vecs[i].rd;
      bus.rd_tag_in       = vecs[i].rtag;
      bus.commit_valid_in = vecs[i].cv;
      bus.commit_rd_in    = vecs[i].crd;
      bus.commit_tag_in   = vecs[i].ctag;
      bus.commit_value_in = vecs[i].cval;
      bus.flush_in        = vecs[i].fl;
      bus.rs1_in          = vecs[i].rs1;
      bus.rs2_in          = vecs[i].rs2;
      #2;
      check($sformatf("v%0d_ready", i), 32'(bus.ready_out), 32'd1);
      check_operand($sformatf("v%0d_rs1", i), vecs[i].rs1, vecs[i].eb1, vecs[i].ev1, vecs[i].et1,
                    bus.rs1_busy_out, bus.rs1_value_out, bus.rs1_tag_out);
      check_operand($sformatf("v%0d_rs2", i), vecs[i].rs2, vecs[i].eb2, vecs[i].ev2, vecs[i].et2,
                    bus.rs2_busy_out, bus.rs2_value_out, bus.rs2_tag_out);
      step();
    end
    idle_inputs();

    // rdy_in low in RUN: an issue must not take effect.
    bus.rdy_in         = 1'b0;
    bus.issue_valid_in = 1'b1;
    bus.rd_in          = 5'd10;
    bus.rd_tag_in      = 4'd2;
    step();
    bus.rdy_in = 1'b1;
    idle_inputs();
    bus.rs1_in = 5'd10;
    #1;
    check("hold_x10_busy", 32'(bus.rs1_busy_out), 32'd0);

    // Leave x9 renamed, then reset mid-run.
    bus.issue_valid_in = 1'b1;
    bus.rd_in          = 5'd9;
    bus.rd_tag_in      = 4'd5;
    step();
    idle_inputs();
    bus.rs1_in = 5'd9;
    #1;
    check("pre_reset_x9_busy", 32'(bus.rs1_busy_out), 32'd1);
    rst_n_in = 1'b0;
    step();
    rst_n_in = 1'b1;
    check("midreset_ready", 32'(bus.ready_out), 32'd0);

    cyc = 0;
    while (!bus.ready_out && cyc < 40) begin
      step();
      cyc++;
    end
    check("reinit_cycles", 32'(cyc), 32'd32);
    check_all_zero("post_reinit");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
